block_stack_tracker: RTL and testbench
======================================

Name: block_stack_tracker

Overview:
- Parametrised successor to the single-layer previous-block register in the stacker game.
- Keeps the full history of placed layers, DEPTH deep, and computes the overlap of the moving block with the top layer internally on each stop.
- Trims the placed block to that overlap and declares game-over on a miss or a win on reaching DEPTH layers.
- Sits between the input/stop controller and the renderer. The renderer reads any stored layer through a registered read port.

Parameters:
- XW, 9, bit width of horizontal pixel coordinates.
- DEPTH, 12, maximum number of layers, including the base. Must be >= 2.
- LW, $clog2(DEPTH+1), width of the level counter. Derived; not overridden.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- init_valid  in  1  load base layer, single-cycle pulse
- init_start  in  XW  base layer left edge, inclusive
- init_end  in  XW  base layer right edge, inclusive
- place_valid  in  1  stop pressed; moving block to be placed
- place_ready  out  1  tracker can accept a placement
- move_start  in  XW  moving block left edge, inclusive
- move_end  in  XW  moving block right edge, inclusive
- result_valid  out  1  one-cycle pulse: placement result available
- result_hit  out  1  last placement overlapped the top layer
- top_start  out  XW  current top layer left edge
- top_end  out  XW  current top layer right edge
- top_width  out  XW  top_end - top_start + 1
- level  out  LW  number of stored layers
- game_over  out  1  sticky; last placement missed
- win  out  1  sticky; level reached DEPTH
- rd_level  in  LW  renderer read index, 0 = base
- rd_start  out  XW  read data, left edge; 1-cycle latency
- rd_end  out  XW  read data, right edge; 1-cycle latency

Behaviour:
- Reset:
  - State goes to S_IDLE.
  - All outputs are 0: level, top_*, result_*, game_over, win, rd_*, place_ready.
  - Reset sampled during S_CALC aborts the placement; no result_valid is produced.
- States: S_IDLE, S_PLAY, S_CALC, S_OVER, S_WIN. place_ready = (state == S_PLAY).
- Init:
  - init_valid is honoured in S_IDLE, S_OVER and S_WIN only.
  - If init_start <= init_end, the base is written to layer 0, top is loaded with it, level = 1, game_over = win = 0, and the next state is S_PLAY.
  - If init_start > init_end, the init is ignored and the state is unchanged.
  - In S_PLAY or S_CALC, init_valid is ignored, even when it coincides with place_valid.
- Place:
  - A placement is accepted on the cycle t where place_valid && place_ready. move_* is captured at that edge.
  - Cycle t+1 is S_CALC:
    - lo = max(move_start, top_start), hi = min(move_end, top_end).
    - hit = (lo <= hi) && (move_start <= move_end).
  - At the end of t+1, on hit:
    - layer[level] = {lo, hi}; top = {lo, hi}; level increments.
    - Next state is S_WIN, with win set, if the new level == DEPTH; otherwise S_PLAY.
  - At the end of t+1, on miss: top and level are unchanged, game_over is set, and the next state is S_OVER.
  - result_valid = 1 and result_hit = hit during cycle t+2 only. Accept-to-result latency is 2.
  - The earliest next acceptance is cycle t+2. place_valid during S_CALC is dropped.
- Boundaries:
  - Exact-edge touch (move_end == top_start) is a hit of width 1.
  - Full containment either way yields the smaller extent.
  - Coordinates are unsigned; no wrap handling is needed because max/min never overflow.
  - top_width is computed from registered top values, so it is valid in the same cycle as top.
- Read port:
  - rd_start/rd_end register layer[rd_level] when rd_level < level; otherwise they register 0.
  - Latency is 1 cycle, the port is always active, and it is independent of the FSM.
- Storage: DEPTH x 2·XW register array. Layers at or above level are stale but masked on read, so no clear is needed.

Decomposition:
- Package block_stack_pkg holds:
  - XW default;
  - typedef layer_t, a struct {start, end};
  - typedef state_t, an enum of the five states;
  - function layer_width(layer_t).
- Sub-module block_overlap: combinational; inputs are the two layer_t values; outputs are lo, hi and hit. It is instantiated once in the CALC datapath.

Test Plan:
- Reset then init 100..199 -> level=1, top=100..199, top_width=100, place_ready=1 next cycle.
- Place 150..249 from top 100..199 -> cycle t+2 result_valid=1, hit=1, top=150..199, width=50, level=2; rd_level=1 -> rd=150..199 one cycle later.
- Place 0..99 on top 100..199 -> hit=0, game_over=1, place_ready=0, top unchanged; then init 10..20 -> S_PLAY, level=1, game_over=0.
- Touch case: top 100..199, place 199..298 -> hit, top=199..199, width=1.
- DEPTH=3: two hits after init -> level=3, win=1, place_ready=0; further place_valid ignored, no result_valid.
- place_valid held high through S_CALC, plus init_valid in S_PLAY -> exactly one accept per 2 cycles, init ignored. Assert resetn=0 in S_CALC -> no result_valid, level=0.

Source files
------------

// File: rtl/block_stack_pkg.sv
// Shared types for the stacker layer tracker.
// Layer extents, FSM states and a width helper.
package block_stack_pkg;

  localparam int XW_DEF = 9;

  typedef struct packed {
    logic [XW_DEF-1:0] l_start;
    logic [XW_DEF-1:0] l_end;
  } layer_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_CALC,
    S_OVER,
    S_WIN
  } state_t;

  function automatic logic [XW_DEF-1:0] layer_width(
    input layer_t l
  );
    return l.l_end - l.l_start + XW_DEF'(1);
  endfunction

endpackage

// File: rtl/block_overlap.sv
// Overlap of the moving block with the top layer.
// Pure combinational max/min; no wrap since coordinates are unsigned.
module block_overlap
  import block_stack_pkg::*;
#(
  parameter type T = layer_t
) (
  input  T                          move_i,
  input  T                          top_i,
  output logic [$bits(T)/2-1:0]     lo_o,
  output logic [$bits(T)/2-1:0]     hi_o,
  output logic                      hit_o
);

  always_comb begin
    lo_o = (move_i.l_start > top_i.l_start) ?
           move_i.l_start : top_i.l_start;
    hi_o = (move_i.l_end < top_i.l_end) ?
           move_i.l_end : top_i.l_end;
    hit_o = (lo_o <= hi_o) &&
            (move_i.l_start <= move_i.l_end);
  end

endmodule

// File: rtl/block_stack_tracker.sv
// Layer history and placement judge for the stacker game.
// Trims each placed block to its overlap with the top layer.
module block_stack_tracker
  import block_stack_pkg::*;
#(
  parameter int XW    = XW_DEF,
  parameter int DEPTH = 12,
  parameter int LW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          init_valid,
  input  logic [XW-1:0] init_start,
  input  logic [XW-1:0] init_end,
  input  logic          place_valid,
  output logic          place_ready,
  input  logic [XW-1:0] move_start,
  input  logic [XW-1:0] move_end,
  output logic          result_valid,
  output logic          result_hit,
  output logic [XW-1:0] top_start,
  output logic [XW-1:0] top_end,
  output logic [XW-1:0] top_width,
  output logic [LW-1:0] level,
  output logic          game_over,
  output logic          win,
  input  logic [LW-1:0] rd_level,
  output logic [XW-1:0] rd_start,
  output logic [XW-1:0] rd_end
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [XW-1:0] l_start;
    logic [XW-1:0] l_end;
  } lyr_t;

  state_t        state_q, state_d;
  lyr_t          top_q, top_d;
  lyr_t          mv_q, mv_d;
  lyr_t          rd_q;
  logic [XW-1:0] width_q, width_d;
  logic [LW-1:0] level_q, level_d;
  logic          go_q, go_d;
  logic          win_q, win_d;
  logic          rv_q, rv_d;
  logic          rh_q, rh_d;

  lyr_t          layers_q [DEPTH];
  logic          wr_en;
  logic [LW-1:0] wr_idx;
  lyr_t          wr_data;

  logic [XW-1:0] ov_lo, ov_hi;
  logic          ov_hit;
  logic          init_ok;
  logic [LW-1:0] level_inc;

  block_overlap #(
    .T (lyr_t)
  ) u_overlap (
    .move_i (mv_q),
    .top_i  (top_q),
    .lo_o   (ov_lo),
    .hi_o   (ov_hi),
    .hit_o  (ov_hit)
  );

  assign init_ok   = init_valid &&
                     (init_start <= init_end);
  assign level_inc = level_q + LW'(1);

  always_comb begin
    state_d = state_q;
    top_d   = top_q;
    mv_d    = mv_q;
    level_d = level_q;
    go_d    = go_q;
    win_d   = win_q;
    rv_d    = 1'b0;
    rh_d    = rh_q;
    wr_en   = 1'b0;
    wr_idx  = level_q;
    wr_data = '{l_start: ov_lo, l_end: ov_hi};

    unique case (state_q)
      S_IDLE, S_OVER, S_WIN: begin
        if (init_ok) begin
          top_d   = '{l_start: init_start,
                      l_end:   init_end};
          level_d = LW'(1);
          go_d    = 1'b0;
          win_d   = 1'b0;
          wr_en   = 1'b1;
          wr_idx  = '0;
          wr_data = top_d;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (place_valid) begin
          mv_d    = '{l_start: move_start,
                      l_end:   move_end};
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        rv_d = 1'b1;
        rh_d = ov_hit;
        if (ov_hit) begin
          wr_en   = 1'b1;
          top_d   = wr_data;
          level_d = level_inc;
          if (level_inc == LW'(DEPTH)) begin
            win_d   = 1'b1;
            state_d = S_WIN;
          end else begin
            state_d = S_PLAY;
          end
        end else begin
          go_d    = 1'b1;
          state_d = S_OVER;
        end
      end
      default: state_d = S_IDLE;
    endcase

    width_d = top_d.l_end - top_d.l_start + XW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      top_q   <= '0;
      mv_q    <= '0;
      width_q <= '0;
      level_q <= '0;
      go_q    <= 1'b0;
      win_q   <= 1'b0;
      rv_q    <= 1'b0;
      rh_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      mv_q    <= mv_d;
      width_q <= width_d;
      level_q <= level_d;
      go_q    <= go_d;
      win_q   <= win_d;
      rv_q    <= rv_d;
      rh_q    <= rh_d;
      // layers at or above level are stale, so mask them
      if (rd_level < level_q)
        rd_q <= layers_q[rd_level[AW-1:0]];
      else
        rd_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en)
      layers_q[wr_idx[AW-1:0]] <= wr_data;
  end

  assign place_ready  = (state_q == S_PLAY);
  assign result_valid = rv_q;
  assign result_hit   = rh_q;
  assign top_start    = top_q.l_start;
  assign top_end      = top_q.l_end;
  assign top_width    = width_q;
  assign level        = level_q;
  assign game_over    = go_q;
  assign win          = win_q;
  assign rd_start     = rd_q.l_start;
  assign rd_end       = rd_q.l_end;

endmodule

// File: tb/tb_block_stack_tracker.sv
// Directed bench for block_stack_tracker.
// Checks a DEPTH=12 and a DEPTH=3 instance.
module tb_block_stack_tracker;

  localparam int XW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic          resetn, iv, pv, pr, rv, rh, go, wn;
  logic [XW-1:0] is, ie, ms, me, ts, te, tw, rs, re;
  logic [3:0]    lv, rl;

  logic          resetn3, iv3, pv3, pr3, rv3, rh3, go3, wn3;
  logic [XW-1:0] is3, ie3, ms3, me3, ts3, te3, tw3, rs3, re3;
  logic [1:0]    lv3, rl3;

  block_stack_tracker #(.XW(XW), .DEPTH(12)) dut (
    .clk(clk), .resetn(resetn),
    .init_valid(iv), .init_start(is), .init_end(ie),
    .place_valid(pv), .place_ready(pr),
    .move_start(ms), .move_end(me),
    .result_valid(rv), .result_hit(rh),
    .top_start(ts), .top_end(te), .top_width(tw),
    .level(lv), .game_over(go), .win(wn),
    .rd_level(rl), .rd_start(rs), .rd_end(re)
  );

  block_stack_tracker #(.XW(XW), .DEPTH(3)) dut3 (
    .clk(clk), .resetn(resetn3),
    .init_valid(iv3), .init_start(is3), .init_end(ie3),
    .place_valid(pv3), .place_ready(pr3),
    .move_start(ms3), .move_end(me3),
    .result_valid(rv3), .result_hit(rh3),
    .top_start(ts3), .top_end(te3), .top_width(tw3),
    .level(lv3), .game_over(go3), .win(wn3),
    .rd_level(rl3), .rd_start(rs3), .rd_end(re3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_top(input string tag,
                         input int s, input int e,
                         input int w, input int l);
    chk({tag, ".ts"}, 32'(ts), 32'(s));
    chk({tag, ".te"}, 32'(te), 32'(e));
    chk({tag, ".tw"}, 32'(tw), 32'(w));
    chk({tag, ".lv"}, 32'(lv), 32'(l));
  endtask

  initial begin
    resetn = 0; iv = 0; pv = 0; rl = '0;
    is = '0; ie = '0; ms = '0; me = '0;
    resetn3 = 0; iv3 = 0; pv3 = 0; rl3 = '0;
    is3 = '0; ie3 = '0; ms3 = '0; me3 = '0;
    tick(); tick();
    chk_top("rst", 0, 0, 0, 0);
    chk("rst.pr", 32'(pr), 0);
    chk("rst.rv", 32'(rv), 0);
    chk("rst.rh", 32'(rh), 0);
    chk("rst.go", 32'(go), 0);
    chk("rst.win", 32'(wn), 0);
    chk("rst.rs", 32'(rs), 0);
    chk("rst.re", 32'(re), 0);

    // init 100..199
    resetn = 1;
    iv = 1; is = 100; ie = 199;
    tick(); iv = 0;
    chk_top("init", 100, 199, 100, 1);
    chk("init.pr", 32'(pr), 1);

    // place 150..249 -> hit 150..199
    pv = 1; ms = 150; me = 249;
    tick(); pv = 0;
    chk("p1.t1.pr", 32'(pr), 0);
    chk("p1.t1.rv", 32'(rv), 0);
    tick();
    chk("p1.rv", 32'(rv), 1);
    chk("p1.rh", 32'(rh), 1);
    chk_top("p1", 150, 199, 50, 2);
    chk("p1.pr", 32'(pr), 1);
    rl = 4'd1;
    tick();
    chk("p1.rv_off", 32'(rv), 0);
    chk("rd1.s", 32'(rs), 150);
    chk("rd1.e", 32'(re), 199);
    rl = 4'd2;
    tick();
    chk("rd2_masked.s", 32'(rs), 0);
    rl = 4'd0;
    tick();
    chk("rd0.s", 32'(rs), 100);
    chk("rd0.e", 32'(re), 199);

    // place 0..99 -> miss
    pv = 1; ms = 0; me = 99;
    tick(); pv = 0;
    tick();
    chk("miss.rv", 32'(rv), 1);
    chk("miss.rh", 32'(rh), 0);
    chk("miss.go", 32'(go), 1);
    chk("miss.pr", 32'(pr), 0);
    chk_top("miss", 150, 199, 50, 2);

    // inverted init ignored in S_OVER
    iv = 1; is = 50; ie = 40;
    tick(); iv = 0;
    chk("badinit.go", 32'(go), 1);
    chk("badinit.pr", 32'(pr), 0);
    chk("badinit.lv", 32'(lv), 2);

    iv = 1; is = 10; ie = 20;
    tick(); iv = 0;
    chk_top("reinit", 10, 20, 11, 1);
    chk("reinit.go", 32'(go), 0);
    chk("reinit.pr", 32'(pr), 1);

    // touch case: top 100..199, place 199..298
    resetn = 0; tick(); resetn = 1;
    iv = 1; is = 100; ie = 199;
    tick(); iv = 0;
    pv = 1; ms = 199; me = 298;
    tick(); pv = 0;
    tick();
    chk("touch.rh", 32'(rh), 1);
    chk_top("touch", 199, 199, 1, 2);

    // held place_valid + init in S_PLAY
    pv = 1; ms = 0; me = 400;
    iv = 1; is = 5; ie = 6;
    tick();
    chk("hold1.rv", 32'(rv), 0);
    chk("hold1.pr", 32'(pr), 0);
    tick();
    chk("hold2.rv", 32'(rv), 1);
    chk("hold2.lv", 32'(lv), 3);
    chk("hold2.pr", 32'(pr), 1);
    tick();
    chk("hold3.rv", 32'(rv), 0);
    tick();
    chk("hold4.rv", 32'(rv), 1);
    pv = 0; iv = 0;
    tick();
    chk("hold5.rv", 32'(rv), 0);
    chk_top("hold5", 199, 199, 1, 4);

    // reset during S_CALC
    pv = 1; ms = 199; me = 199;
    tick(); pv = 0;
    resetn = 0;
    tick();
    chk("rcalc.rv", 32'(rv), 0);
    chk("rcalc.lv", 32'(lv), 0);
    chk("rcalc.pr", 32'(pr), 0);
    resetn = 1;
    tick();
    chk("rcalc2.rv", 32'(rv), 0);
    chk("rcalc2.lv", 32'(lv), 0);

    // containment: move inside top
    iv = 1; is = 100; ie = 199;
    tick(); iv = 0;
    pv = 1; ms = 120; me = 130;
    tick(); pv = 0;
    tick();
    chk("cont.rh", 32'(rh), 1);
    chk_top("cont", 120, 130, 11, 2);

    // DEPTH=3 instance
    tick();
    resetn3 = 1;
    iv3 = 1; is3 = 0; ie3 = 99;
    tick(); iv3 = 0;
    chk("d3.init.lv", 32'(lv3), 1);
    pv3 = 1; ms3 = 10; me3 = 89;
    tick(); pv3 = 0;
    tick();
    chk("d3.p1.lv", 32'(lv3), 2);
    chk("d3.p1.win", 32'(wn3), 0);
    pv3 = 1; ms3 = 20; me3 = 50;
    tick(); pv3 = 0;
    tick();
    chk("d3.p2.rv", 32'(rv3), 1);
    chk("d3.p2.lv", 32'(lv3), 3);
    chk("d3.p2.win", 32'(wn3), 1);
    chk("d3.p2.pr", 32'(pr3), 0);
    chk("d3.p2.ts", 32'(ts3), 20);
    chk("d3.p2.tw", 32'(tw3), 31);
    pv3 = 1;
    tick();
    chk("d3.x1.rv", 32'(rv3), 0);
    tick();
    chk("d3.x2.rv", 32'(rv3), 0);
    chk("d3.x2.lv", 32'(lv3), 3);
    pv3 = 0;
    rl3 = 2'd2;
    tick();
    chk("d3.rd2.s", 32'(rs3), 20);
    chk("d3.rd2.e", 32'(re3), 50);
    rl3 = 2'd3;
    tick();
    chk("d3.rd3.e", 32'(re3), 0);
    iv3 = 1; is3 = 0; ie3 = 9;
    tick(); iv3 = 0;
    chk("d3.reinit.lv", 32'(lv3), 1);
    chk("d3.reinit.win", 32'(wn3), 0);
    chk("d3.reinit.pr", 32'(pr3), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
